// File: rtl/vm_pkg.sv
// Shared coin codes, denomination values, FSM state type and the coin value lookup.
// Pure package: no latency, no flow control.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  localparam logic [4:0] VAL_5  = 5'd5;
  localparam logic [4:0] VAL_10 = 5'd10;
  localparam logic [4:0] VAL_25 = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } vm_state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      COIN_25: coin_value = VAL_25;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Greedy change picker: largest coin not exceeding the credit (25, 10, else 5).
// Combinational, zero latency; no flow control.
module vm_change_gen
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin_code,
  output logic [CREDIT_W-1:0] coin_val
);

  always_comb begin
    coin_code = COIN_5;
    coin_val  = CREDIT_W'(VAL_5);
    if (credit >= CREDIT_W'(VAL_25)) begin
      coin_code = COIN_25;
      coin_val  = CREDIT_W'(VAL_25);
    end else if (credit >= CREDIT_W'(VAL_10)) begin
      coin_code = COIN_10;
      coin_val  = CREDIT_W'(VAL_10);
    end
  end

endmodule

// File: rtl/vm_multi.sv
// Multi-product vending controller: credit, vend, greedy change; stock tracking when VM_STOCK_EN is defined.
// Outputs registered (1 cycle); busy refuses coins/selections with reject pulses instead of stalling.
module vm_multi
  import vm_pkg::*;
#(
  parameter int NUM_PROD   = 4,
  parameter int SEL_W      = $clog2(NUM_PROD),
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   coin,
  input  logic                         cancel,
  input  logic                         sel_valid,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_PROD*CREDIT_W-1:0] price,
  input  logic [NUM_PROD-1:0]          refill,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy,
  output logic                         vend_valid,
  output logic [SEL_W-1:0]             vend_id,
  output logic                         change_valid,
  output logic [1:0]                   change_coin,
  output logic                         coin_reject,
  output logic                         sel_reject,
  output logic [NUM_PROD-1:0]          sold_out
);

  vm_state_t state;

  logic [1:0]          chg_code;
  logic [CREDIT_W-1:0] chg_val;
  logic [CREDIT_W-1:0] credit_after_chg;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range;
  logic                sel_sold;
  logic                vend_go;

  vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .credit    (credit),
    .coin_code (chg_code),
    .coin_val  (chg_val)
  );

  assign credit_after_chg = credit - chg_val;

  // Guard bit keeps the ceiling comparison exact near 2^CREDIT_W.
  assign coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin));
  assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

  // Index decode by equality so an out-of-range sel never matches a price slot.
  always_comb begin
    sel_price    = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_price    = price[i*CREDIT_W +: CREDIT_W];
        sel_in_range = 1'b1;
      end
    end
  end

  assign vend_go = (state == ST_IDLE) && !cancel && (coin == COIN_NONE) && sel_valid &&
                   sel_in_range && (credit >= sel_price) && !sel_sold;

`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] stock     [NUM_PROD];
  logic [STOCK_W-1:0] stock_nxt [NUM_PROD];

  always_comb begin
    sel_sold = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel == SEL_W'(i) && stock[i] == '0) sel_sold = 1'b1;
    end
  end

  // Refill is applied after the vend decrement so it wins on a collision.
  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      stock_nxt[i] = stock[i];
      if (vend_go && sel == SEL_W'(i)) stock_nxt[i] = stock[i] - 1'b1;
      if (refill[i]) stock_nxt[i] = STOCK_W'(INIT_STOCK);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROD; i++) begin
      if (reset) begin
        stock[i]    <= STOCK_W'(INIT_STOCK);
        sold_out[i] <= 1'b0;
      end else begin
        stock[i]    <= stock_nxt[i];
        sold_out[i] <= (stock_nxt[i] == '0);
      end
    end
  end
`else
  logic unused_stock_cfg;
  assign unused_stock_cfg = ^{refill, STOCK_W[0], INIT_STOCK[0]};
  assign sel_sold         = 1'b0;
  assign sold_out         = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      busy         <= 1'b0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_coin  <= COIN_NONE;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
    end else begin
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= COIN_NONE;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cancel) begin
            coin_reject <= (coin != COIN_NONE);
            sel_reject  <= sel_valid;
            if (credit != '0) begin
              // First refund coin leaves on the cancel edge itself.
              change_valid <= 1'b1;
              change_coin  <= chg_code;
              credit       <= credit_after_chg;
              state        <= (credit_after_chg == '0) ? ST_IDLE : ST_CHANGE;
              busy         <= (credit_after_chg != '0);
            end
          end else if (coin != COIN_NONE) begin
            sel_reject <= sel_valid;
            if (coin_fits) credit <= coin_sum[CREDIT_W-1:0];
            else           coin_reject <= 1'b1;
          end else if (sel_valid) begin
            if (vend_go) begin
              vend_valid <= 1'b1;
              vend_id    <= sel;
              credit     <= credit - sel_price;
              state      <= ST_DISPENSE;
              busy       <= 1'b1;
            end else begin
              sel_reject <= 1'b1;
            end
          end
        end
        ST_DISPENSE, ST_CHANGE: begin
          coin_reject <= (coin != COIN_NONE);
          sel_reject  <= sel_valid;
          if (credit == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            // DISPENSE already emits the first change coin so change starts at t+2.
            change_valid <= 1'b1;
            change_coin  <= chg_code;
            credit       <= credit_after_chg;
            state        <= (credit_after_chg == '0) ? ST_IDLE : ST_CHANGE;
            busy         <= (credit_after_chg != '0);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_multi.sv
// Scoreboard bench for vm_multi: directed scenarios then randomized traffic against a transaction-level model.
module tb_vm_multi;

  localparam int NP   = 4;
  localparam int INIT = 1;
  localparam int MAXC = 200;
`ifdef VM_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  bit         clk;
  logic       reset, cancel, sel_valid;
  logic [1:0] coin, sel;
  logic [31:0] price;
  logic [3:0] refill;
  logic [7:0] credit;
  logic       busy, vend_valid, change_valid, coin_reject, sel_reject;
  logic [1:0] vend_id, change_coin;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vm_multi #(.NUM_PROD(NP), .CREDIT_W(8), .MAX_CREDIT(MAXC), .STOCK_W(4), .INIT_STOCK(INIT)) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel), .sel_valid(sel_valid), .sel(sel),
    .price(price), .refill(refill), .credit(credit), .busy(busy), .vend_valid(vend_valid),
    .vend_id(vend_id), .change_valid(change_valid), .change_coin(change_coin),
    .coin_reject(coin_reject), .sel_reject(sel_reject), .sold_out(sold_out)
  );

  typedef struct {
    bit       rst_chk;
    int       credit;
    bit       busy, vv, cv, cr, sr;
    int       vid, cc;
    bit [3:0] so;
  } exp_t;

  exp_t exp_q[$];
  exp_t plan[$];
  int   m_credit, m_stock[NP];
  bit   m_busy;
  int   checks, failures, cyc_no;

  function automatic int value_of(input int code);
    return (code == 1) ? 5 : (code == 2) ? 10 : (code == 3) ? 25 : 0;
  endfunction

  function automatic exp_t blank(input int cr_val, input bit bz);
    exp_t r;
    r.rst_chk = 0; r.credit = cr_val; r.busy = bz; r.vv = 0; r.cv = 0;
    r.cr = 0; r.sr = 0; r.vid = 0; r.cc = 0; r.so = '0;
    return r;
  endfunction

  // Refund as a list of future cycles, largest denomination first.
  task automatic make_change(input int amt, input bit after_vend);
    exp_t r;
    if (amt == 0 && after_vend) plan.push_back(blank(0, 0));
    while (amt > 0) begin
      int v;
      v = (amt >= 25) ? 25 : (amt >= 10) ? 10 : 5;
      amt -= v;
      r = blank(amt, amt > 0);
      r.cv = 1;
      r.cc = (v == 25) ? 3 : (v == 10) ? 2 : 1;
      plan.push_back(r);
    end
  endtask

  task automatic model(input bit rs, input bit c, input int cn, input bit sv, input int s, input bit [3:0] rf);
    exp_t r;
    bit cr, sr;
    int p;
    cr = 0; sr = 0;
    if (rs) begin
      plan.delete();
      m_credit = 0; m_busy = 0;
      foreach (m_stock[i]) m_stock[i] = INIT;
      r = blank(0, 0);
      r.rst_chk = 1;
      exp_q.push_back(r);
      return;
    end
    if (m_busy) begin
      r  = plan.pop_front();
      cr = (cn != 0);
      sr = sv;
    end else begin
      r = blank(m_credit, 0);
      if (c) begin
        cr = (cn != 0); sr = sv;
        if (m_credit > 0) begin
          make_change(m_credit, 0);
          r = plan.pop_front();
        end
      end else if (cn != 0) begin
        sr = sv;
        if (m_credit + value_of(cn) <= MAXC) r.credit = m_credit + value_of(cn);
        else cr = 1;
      end else if (sv) begin
        p = (price >> (s * 8)) & 32'hFF;
        if (m_credit >= p && (!STOCK_EN || m_stock[s] > 0)) begin
          r.vv = 1; r.vid = s; r.credit = m_credit - p; r.busy = 1;
          m_stock[s]--;
          make_change(m_credit - p, 1);
        end else begin
          sr = 1;
        end
      end
    end
    for (int i = 0; i < NP; i++) if (rf[i]) m_stock[i] = INIT;
    r.cr = cr; r.sr = sr;
    for (int i = 0; i < NP; i++) r.so[i] = STOCK_EN && (m_stock[i] == 0);
    m_credit = r.credit;
    m_busy   = r.busy;
    exp_q.push_back(r);
  endtask

  task automatic cyc(input bit rs, input bit c, input int cn, input bit sv, input int s, input bit [3:0] rf);
    reset = rs; cancel = c; coin = 2'(cn); sel_valid = sv; sel = 2'(s); refill = rf;
    model(rs, c, cn, sv, s, rf);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 20) begin
      cyc(0, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL drain_timeout busy=%0b required=0 after %0d cycles", busy, n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit bad;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      bad = (credit !== 8'(e.credit)) || (busy !== e.busy) || (vend_valid !== e.vv) ||
            (change_valid !== e.cv) || (coin_reject !== e.cr) || (sel_reject !== e.sr) ||
            (sold_out !== e.so);
      if ((e.vv || e.rst_chk) && vend_id !== 2'(e.vid)) bad = 1;
      if ((e.cv || e.rst_chk) && change_coin !== 2'(e.cc)) bad = 1;
      if (bad) begin
        failures++;
        $display("FAIL cycle%0d got credit=%0d busy=%0b vend=%0b/%0d chg=%0b/%0d crej=%0b srej=%0b so=%b required credit=%0d busy=%0b vend=%0b/%0d chg=%0b/%0d crej=%0b srej=%0b so=%b",
                 cyc_no, credit, busy, vend_valid, vend_id, change_valid, change_coin, coin_reject,
                 sel_reject, sold_out, e.credit, e.busy, e.vv, e.vid, e.cv, e.cc, e.cr, e.sr, e.so);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    price = {8'd50, 8'd35, 8'd20, 8'd15};
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // 40 credit, product 1 (20) -> vend then 10,10
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 2, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    drain();

    // 30 credit cancel, coin thrown in during change
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);
    drain(); idle(1);

    // too little credit for product 2
    cyc(0, 0, 2, 0, 0, 0); cyc(0, 0, 0, 1, 2, 0); idle(1);
    cyc(0, 1, 0, 0, 0, 0); drain();

    // ceiling: 190 + 25 rejected, + 10 reaches 200
    for (int i = 0; i < 7; i++) cyc(0, 0, 3, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 2, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); drain();

    // coin beats selection; cancel with zero credit is a no-op
    cyc(0, 0, 3, 1, 0, 0); cyc(0, 1, 0, 0, 0, 0); drain();
    cyc(0, 1, 2, 1, 0, 0); idle(1);

    // stock: product 0 twice, refill, exact-price vend, refill colliding with vend
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0); drain();
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0); idle(1); cyc(0, 1, 0, 0, 0, 0); drain();
    cyc(0, 0, 0, 0, 0, 4'b0001); idle(1);
    cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 3, 0, 0, 0); cyc(0, 0, 0, 1, 3, 4'b1000); drain();

    // reset in the middle of a refund
    for (int i = 0; i < 4; i++) cyc(0, 0, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); idle(2);

    for (int n = 0; n < 4000; n++) begin
      bit rs, c, sv;
      int cn, s;
      bit [3:0] rf;
      if ($urandom_range(0, 99) == 0 && !busy)
        for (int i = 0; i < NP; i++) price[i*8 +: 8] = 8'(5 * $urandom_range(1, 20));
      rs = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 11) == 0);
      cn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      sv = ($urandom_range(0, 9) < 4);
      s  = $urandom_range(0, NP - 1);
      rf = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, NP - 1)) : 4'b0;
      cyc(rs, c, cn, sv, s, rf);
    end
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
